// File: rtl/gcd_ctrl.sv
// Euclidean GCD sequencer: loops a,b through an external modulo unit until b == 0.
// Optional out_iter port (modulo-call count) is enabled by defining GCD_ITER_CNT_EN.
module gcd_ctrl #(
  parameter int WIDTH  = 64,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_gcd,
  output logic              mod_start,
  output logic [WIDTH-1:0]  mod_dividend,
  output logic [WIDTH-1:0]  mod_divisor,
  input  logic              mod_done,
  input  logic [WIDTH-1:0]  mod_remainder,
`ifdef GCD_ITER_CNT_EN
  output logic [ITER_W-1:0] out_iter,
`endif
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // out_valid stays high with out_gcd stable until that edge, and valid
  // never waits on ready.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [ITER_W-1:0]  iter;
  logic               b_zero;

  assign b_zero       = (b_r == '0);
  assign mod_dividend = a_r;
  assign mod_divisor  = b_r;
  assign dbg_state    = state;
`ifdef GCD_ITER_CNT_EN
  assign out_iter     = iter;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mod_start = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_CHECK;
      end
      S_CHECK:  state_nxt = b_zero ? S_RESULT : S_ISSUE;
      S_ISSUE: begin
        mod_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:   if (mod_done) state_nxt = S_CHECK;
      S_RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Operands only move on accept or on a completed remainder, so the modulo
  // inputs hold steady from ISSUE through the mod_done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      out_gcd <= '0;
      iter    <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_r  <= in_a;
          b_r  <= in_b;
          iter <= '0;
        end
        S_CHECK: if (b_zero) out_gcd <= a_r;
        S_WAIT: if (mod_done) begin
          a_r  <= b_r;
          b_r  <= mod_remainder;
          iter <= iter + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl: vector table, reset-abort sequence and random jobs
// against a modulo-unit responder and an arithmetic Euclid model.
module tb_gcd_ctrl;
  localparam int W  = 64;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_gcd;
  logic          mod_start;
  logic [W-1:0]  mod_dividend;
  logic [W-1:0]  mod_divisor;
  logic          mod_done = 1'b0;
  logic [W-1:0]  mod_remainder = '0;
  logic [2:0]    dbg_state;
`ifdef GCD_ITER_CNT_EN
  logic [IW-1:0] out_iter;
`endif

  gcd_ctrl #(.WIDTH(W), .ITER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .mod_start(mod_start), .mod_dividend(mod_dividend), .mod_divisor(mod_divisor),
    .mod_done(mod_done), .mod_remainder(mod_remainder),
`ifdef GCD_ITER_CNT_EN
    .out_iter(out_iter),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: expected modulo calls {dividend, divisor} ----------------
  logic [2*W-1:0] exp_q[$];

  // Euclid from its definition: gcd(a,0)=a, gcd(a,b)=gcd(b, a mod b).
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                                output logic [W-1:0] g, output int k);
    logic [W-1:0] x, y, r;
    x = a; y = b; k = 0;
    while (y != 0) begin
      if (push) exp_q.push_back({x, y});
      r = x % y;
      x = y; y = r; k++;
    end
    g = x;
  endfunction

  // ---------------- modulo unit responder ----------------
  int mod_lat   = 2;
  int call_cnt  = 0;
  bit rsp_abort = 0;
  bit rsp_busy  = 0;

  initial begin : responder
    logic [W-1:0]   pa, pb;
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (mod_start) begin
        rsp_busy = 1;
        call_cnt++;
        pa = mod_dividend;
        pb = mod_divisor;
        if (exp_q.size() == 0) begin
          chk("mod_call_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("mod_call_dividend", pa, e[2*W-1:W]);
          chk("mod_call_divisor", pb, e[W-1:0]);
        end
        chk("mod_divisor_nonzero", W'(pb != 0), 1);
        for (int i = 1; i <= mod_lat; i++) begin
          @(negedge clk);
          if (!rsp_abort) begin
            if (i == 1) chk("mod_start_pulse", W'(mod_start), 0);
            chk("mod_dividend_stable", mod_dividend, pa);
            chk("mod_divisor_stable", mod_divisor, pb);
          end
        end
        mod_done      = 1'b1;
        mod_remainder = (pb == 0) ? '0 : pa % pb;
        @(negedge clk);
        mod_done      = 1'b0;
        mod_remainder = {$urandom, $urandom};
        rsp_busy = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                         input logic [W-1:0] exp_g, input int exp_k, input int hold);
    logic [W-1:0] mg;
    int mk, cyc;
    model(a, b, 1'b1, mg, mk);
    mod_lat  = lat;
    call_cnt = 0;
    chk("in_ready_idle", W'(in_ready), 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    cyc = 1;
    while (!out_valid && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", W'(cyc), W'(2 + exp_k * (2 + lat)));
    chk("out_gcd", out_gcd, exp_g);
    chk("mod_call_count", W'(call_cnt), W'(exp_k));
    chk("in_ready_busy", W'(in_ready), 0);
`ifdef GCD_ITER_CNT_EN
    chk("out_iter", W'(out_iter), W'(exp_k % (1 << IW)));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = {$urandom, $urandom};
      in_b = W'($urandom_range(0, 3));
      @(negedge clk);
      chk("hold_out_valid", W'(out_valid), 1);
      chk("hold_out_gcd", out_gcd, exp_g);
      chk("hold_in_ready", W'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_accept_out_valid", W'(out_valid), 0);
    chk("post_accept_in_ready", W'(in_ready), 1);
    chk("post_accept_state_idle", W'(dbg_state), 0);
    chk("mod_calls_all_issued", W'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    int           k;
    int           lat;
    int           hold;
  } vec_t;

  vec_t vt[7];

  initial begin : main
    logic [W-1:0] ra, rb, rg;
    int rk, mode, bound;

    vt[0] = '{a: 64'd48, b: 64'd18, g: 64'd6,  k: 3,  lat: 2,  hold: 0};
    vt[1] = '{a: 64'd5,  b: 64'd15, g: 64'd5,  k: 2,  lat: 4,  hold: 1};
    vt[2] = '{a: 64'd17, b: 64'd0,  g: 64'd17, k: 0,  lat: 1,  hold: 0};
    vt[3] = '{a: 64'd0,  b: 64'd0,  g: 64'd0,  k: 0,  lat: 1,  hold: 2};
    vt[4] = '{a: 64'd0,  b: 64'd9,  g: 64'd9,  k: 1,  lat: 3,  hold: 0};
    vt[5] = '{a: 64'd7540113804746346429, b: 64'd4660046610375530309,
              g: 64'd1, k: 90, lat: 1, hold: 10};
    vt[6] = '{a: 64'd21, b: 64'd14, g: 64'd7,  k: 2,  lat: 65, hold: 0};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_out_valid", W'(out_valid), 0);
    chk("reset_mod_start", W'(mod_start), 0);
    chk("reset_state", W'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", W'(in_ready), 1);
    chk("reset_out_gcd", out_gcd, 0);
    chk("reset_mod_dividend", mod_dividend, 0);
    chk("reset_mod_divisor", mod_divisor, 0);
`ifdef GCD_ITER_CNT_EN
    chk("reset_out_iter", W'(out_iter), 0);
`endif

    // table of vectors
    for (int i = 0; i < 7; i++)
      run_job(vt[i].a, vt[i].b, vt[i].lat, vt[i].g, vt[i].k, vt[i].hold);

    // reset during WAIT of (48,18), then a stale mod_done
    model(64'd48, 64'd18, 1'b1, rg, rk);
    mod_lat  = 40;
    call_cnt = 0;
    in_a = 64'd48; in_b = 64'd18; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bound = 0;
    while (dbg_state != 3'd3 && bound < 10) begin
      @(negedge clk);
      bound++;
    end
    chk("abort_reached_wait", W'(dbg_state), 3);
    rsp_abort = 1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_async_state", W'(dbg_state), 0);
    chk("abort_async_divisor", mod_divisor, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 60 && rsp_busy; i++) begin
      @(negedge clk);
      chk("abort_idle_state", W'(dbg_state), 0);
      chk("abort_no_out_valid", W'(out_valid), 0);
      chk("abort_no_mod_start", W'(mod_start), 0);
    end
    chk("abort_stale_done_sent", W'(rsp_busy), 0);
    @(negedge clk);
    rsp_abort = 0;
    chk("stale_done_state", W'(dbg_state), 0);
    chk("stale_done_in_ready", W'(in_ready), 1);
    chk("stale_done_out_valid", W'(out_valid), 0);
    run_job(64'd21, 64'd14, 3, 64'd7, 2, 0);

    // random jobs against the model
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin ra = W'($urandom_range(0, 200)); rb = W'($urandom_range(0, 200)); end
        1: begin ra = W'($urandom_range(0, 65535)); rb = W'($urandom_range(0, 65535)); end
        2: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
        default: begin
          ra = ($urandom_range(0, 1) == 1) ? '0 : {$urandom, $urandom};
          rb = (ra == '0) ? W'($urandom) : '0;
        end
      endcase
      model(ra, rb, 1'b0, rg, rk);
      run_job(ra, rb, $urandom_range(1, 5), rg, rk, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
Euclidean GCD sequencer that sits directly upstream of the modulo unit.
- Accepts an operand pair (a, b) over a valid/ready handshake.
- Loops r = a % b; a <= b; b <= r, issuing each remainder request to the modulo unit over its start/done pulse interface, until b == 0.
- Returns gcd = a on a valid/ready result port toward the AXI register layer.

Parameters:
WIDTH, 64, operand/result width in bits; must match the attached modulo unit.
ITER_W, 8, width of the internal iteration counter; wraps modulo 2^ITER_W.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  high only in IDLE
in_a  input  WIDTH  first operand
in_b  input  WIDTH  second operand
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
out_gcd  output  WIDTH  gcd(in_a, in_b)
mod_start  output  1  one-cycle pulse to modulo unit
mod_dividend  output  WIDTH  current a, registered
mod_divisor  output  WIDTH  current b, registered
mod_done  input  1  one-cycle pulse from modulo unit
mod_remainder  input  WIDTH  valid in the mod_done cycle

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, a_r = b_r = 0, out_gcd = 0, out_valid = 0, mod_start = 0, iter = 0; in_ready = 1 after reset release.
- Reset mid-operation aborts immediately. A modulo operation in flight is abandoned; its later mod_done is ignored, since IDLE only reacts to in_valid.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESULT.
- IDLE: in_ready = 1. On in_valid:
  - latch a_r = in_a, b_r = in_b, iter = 0
  - go to CHECK next cycle
- CHECK:
  - b_r == 0: out_gcd <= a_r, go to RESULT.
  - else: go to ISSUE.
- ISSUE:
  - mod_start = 1 for exactly this one cycle.
  - mod_dividend = a_r and mod_divisor = b_r, stable from ISSUE until the mod_done cycle.
  - Go to WAIT.
- WAIT:
  - On mod_done: a_r <= b_r, b_r <= mod_remainder, iter <= iter + 1, go to CHECK.
  - Otherwise stay; no timeout.
  - mod_done outside WAIT is ignored.
- RESULT: out_valid = 1 and out_gcd held stable. On out_ready, go to IDLE next cycle, with out_valid low in that cycle.
- out_valid and out_ready are allowed in the same cycle as the transition into RESULT only through registered out_valid, so the minimum hold is one cycle.
- Latency, in_valid accept to out_valid:
  - = 2 + k*(2 + Tm) cycles, where k = number of modulo calls and Tm = cycles from mod_start to mod_done (WIDTH+1 for the shift-subtract unit).
  - k = 0 gives 2 cycles.
- Boundary conditions:
  - in_b = 0 → gcd = in_a, no modulo call.
  - in_a = 0, in_b = 0 → gcd = 0.
  - in_a = 0, in_b ≠ 0 → one call (0 % b = 0), gcd = in_b.
  - in_a < in_b → first call swaps operands naturally.
  - No divisor of 0 is ever issued.
- in_valid while not IDLE is ignored (in_ready = 0). No back-pressure on the modulo side.

Optional Feature:
GCD_ITER_CNT_EN
- Defined: adds output port out_iter [ITER_W-1:0].
  - Equals the number of modulo calls for the current result.
  - Valid and stable while out_valid = 1; reset value 0; wraps modulo 2^ITER_W.
- Undefined: port absent; the iter register is still allowed but unobservable.
- Core behaviour and timing are identical either way.

Test Plan:
- in_a = 48, in_b = 18 → three mod_start pulses with (48,18), (18,12), (12,6); out_gcd = 6; out_iter = 3 if GCD_ITER_CNT_EN.
- in_a = 5, in_b = 15 → calls (5,15), (15,5); out_gcd = 5, iter = 2. in_a = 17, in_b = 0 → no mod_start; out_valid exactly 2 cycles after accept; out_gcd = 17.
- in_a = 0, in_b = 0 → out_gcd = 0, no mod_start. in_a = 0, in_b = 9 → one call, out_gcd = 9.
- WIDTH = 64, consecutive Fibonacci F(92), F(91) → out_gcd = 1 after 90 calls. Hold out_ready = 0 for 10 cycles → out_valid and out_gcd stable, in_ready = 0, a new in_valid is ignored.
- Assert rst_n low during WAIT of the (48,18) job, then release and later pulse a stale mod_done → out_valid = 0, state IDLE, in_ready = 1. A following (21,14) job returns 7.
